// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out serializer: FSM encoding and
// the counter-width helper.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bits needed to hold the values 0..value-1 (at least 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Modulo-WIDTH bit counter for the serializer; tc flags the last bit of a word.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    output logic [clog2(WIDTH)-1:0]   cnt,
    output logic                      tc
);

    localparam int unsigned CntW = clog2(WIDTH);

    assign tc = (cnt == CntW'(WIDTH - 1));

    // clr wins over en so a word boundary reload always restarts at bit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word pending buffer so that
// back-to-back words stream out with no idle cycle between them.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof
);

    localparam int unsigned CntW = clog2(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   pend_q;
    logic               pend_full_q;
    logic               armed_q;
    logic [CntW-1:0]    cnt;
    logic               tc;
    logic               in_shift;
    logic               accept;
    logic               last;
    logic               reload;
    logic [WIDTH-1:0]   shifted;

    assign in_shift   = (state_q == ST_SHIFT);
    // armed_q keeps load_ready low until the first edge after reset release.
    assign load_ready = armed_q && (!in_shift || !pend_full_q);
    assign accept     = load_valid && load_ready;
    assign last       = in_shift && tc;
    assign reload     = (!in_shift && accept) || (last && (pend_full_q || accept));

    // Zero fill means the register drains to all-zero when a frame ends idle.
    assign shifted = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg_q[WIDTH-1:1]};

    assign sout       = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    assign sout_valid = in_shift;
    assign sof        = in_shift && (cnt == '0);
    assign eof        = last;

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (reload),
        .en  (in_shift),
        .cnt (cnt),
        .tc  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shreg_q <= din;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last) begin
                        if (pend_full_q) begin
                            shreg_q     <= pend_q;
                            pend_full_q <= 1'b0;
                        end else if (accept) begin
                            shreg_q <= din;
                        end else begin
                            shreg_q <= shifted;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        shreg_q <= shifted;
                        if (accept) begin
                            pend_q      <= din;
                            pend_full_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share one
// input stream and are checked every cycle against a word-queue reference model.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] din;

    logic lr_m, so_m, sv_m, sof_m, eof_m;
    logic lr_l, so_l, sv_l, sof_l, eof_l;

    piso_serializer #(
        .WIDTH     (W),
        .MSB_FIRST (1)
    ) u_msb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (lr_m),
        .sout       (so_m),
        .sout_valid (sv_m),
        .sof        (sof_m),
        .eof        (eof_m)
    );

    piso_serializer #(
        .WIDTH     (W),
        .MSB_FIRST (0)
    ) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (lr_l),
        .sout       (so_l),
        .sout_valid (sv_l),
        .sof        (sof_l),
        .eof        (eof_l)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words accepted but not yet fully shifted out, plus the
    // index of the bit currently on the wire for the head word.
    logic [W-1:0] mq[$];
    int           idx;
    bit           armed;

    logic [31:0]  cap_m, cap_l;
    int           cap_n;
    logic [W-1:0] acc_words[$];
    logic [W-1:0] got_words[$];
    logic [W-1:0] deser;
    int           n_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        mq.delete();
        idx   = 0;
        armed = 1'b0;
    endtask

    task automatic clear_cap();
        cap_m = '0;
        cap_l = '0;
        cap_n = 0;
    endtask

    task automatic check_outputs();
        logic [W-1:0] w;
        logic e_sv, e_sm, e_sl, e_sof, e_eof, e_rdy;
        if (mq.size() > 0) begin
            w     = mq[0];
            e_sv  = 1'b1;
            e_sm  = w[W-1-idx];
            e_sl  = w[idx];
            e_sof = (idx == 0);
            e_eof = (idx == W - 1);
        end else begin
            e_sv  = 1'b0;
            e_sm  = 1'b0;
            e_sl  = 1'b0;
            e_sof = 1'b0;
            e_eof = 1'b0;
        end
        e_rdy = armed && (mq.size() < 2);
        chk("msb_sout",       32'(so_m),  32'(e_sm));
        chk("msb_sout_valid", 32'(sv_m),  32'(e_sv));
        chk("msb_sof",        32'(sof_m), 32'(e_sof));
        chk("msb_eof",        32'(eof_m), 32'(e_eof));
        chk("msb_load_ready", 32'(lr_m),  32'(e_rdy));
        chk("lsb_sout",       32'(so_l),  32'(e_sl));
        chk("lsb_sout_valid", 32'(sv_l),  32'(e_sv));
        chk("lsb_sof",        32'(sof_l), 32'(e_sof));
        chk("lsb_eof",        32'(eof_l), 32'(e_eof));
        chk("lsb_load_ready", 32'(lr_l),  32'(e_rdy));
        if (sv_m === 1'b1) begin
            cap_m = {cap_m[30:0], so_m};
            cap_l = {cap_l[30:0], so_l};
            cap_n++;
            deser = {deser[W-2:0], so_m};
            if (eof_m === 1'b1) got_words.push_back(deser);
        end
    endtask

    // Called at a negedge; drives inputs, checks the cycle, advances one edge.
    task automatic tick(input logic lv, input logic [W-1:0] d);
        logic acc;
        load_valid = lv;
        din        = d;
        #1;
        check_outputs();
        acc = lv && armed && (mq.size() < 2);
        @(posedge clk);
        armed = 1'b1;
        if (mq.size() > 0) begin
            idx++;
            if (idx == W) begin
                void'(mq.pop_front());
                idx = 0;
            end
        end
        if (acc) begin
            mq.push_back(d);
            acc_words.push_back(d);
            n_acc++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        load_valid = 1'b0;
        din        = '0;
        deser      = '0;
        n_acc      = 0;
        reset_model();
        clear_cap();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, '0);

        // Single word, MSB first.
        clear_cap();
        tick(1'b1, 4'b1011);
        repeat (5) tick(1'b0, '0);
        chk("t1_bits",  cap_m, 32'hb);
        chk("t1_count", 32'(cap_n), 32'd4);

        // Pending word held off by load_ready, streamed with no gap.
        clear_cap();
        tick(1'b1, 4'b1100);
        repeat (4) tick(1'b1, 4'b0011);
        repeat (8) tick(1'b0, '0);
        chk("t2_bits",  cap_m, 32'hc3);
        chk("t2_count", 32'(cap_n), 32'd8);

        // LSB-first ordering.
        clear_cap();
        tick(1'b1, 4'b0001);
        repeat (5) tick(1'b0, '0);
        chk("t3_lsb_bits", cap_l, 32'h8);
        chk("t3_msb_bits", cap_m, 32'h1);

        // Second word offered exactly on the eof cycle with pending empty.
        clear_cap();
        tick(1'b1, 4'b1010);
        repeat (3) tick(1'b0, '0);
        tick(1'b1, 4'b0101);
        repeat (5) tick(1'b0, '0);
        chk("t4_bits",  cap_m, 32'ha5);
        chk("t4_count", 32'(cap_n), 32'd8);

        // Asynchronous reset mid-frame, then a clean frame.
        tick(1'b1, 4'b1001);
        repeat (2) tick(1'b0, '0);
        #2 rst = 1'b0;
        #1;
        chk("rst_msb_sout",  32'(so_m),  32'd0);
        chk("rst_msb_valid", 32'(sv_m),  32'd0);
        chk("rst_msb_sof",   32'(sof_m), 32'd0);
        chk("rst_msb_eof",   32'(eof_m), 32'd0);
        chk("rst_msb_ready", 32'(lr_m),  32'd0);
        chk("rst_lsb_sout",  32'(so_l),  32'd0);
        chk("rst_lsb_valid", 32'(sv_l),  32'd0);
        reset_model();
        @(negedge clk);
        rst = 1'b1;
        clear_cap();
        tick(1'b0, '0);
        tick(1'b1, 4'b0110);
        repeat (5) tick(1'b0, '0);
        chk("t5_bits",  cap_m, 32'h6);
        chk("t5_count", 32'(cap_n), 32'd4);

        // Random words with random gaps, deserialized and compared in order.
        acc_words.delete();
        got_words.delete();
        n_acc = 0;
        for (int c = 0; c < 400 && n_acc < 40; c++) begin
            tick($urandom_range(0, 3) != 0, W'($urandom));
        end
        chk("rand_accepted", 32'(n_acc), 32'd40);
        repeat (12) tick(1'b0, '0);
        chk("rand_word_count", 32'(got_words.size()), 32'(acc_words.size()));
        for (int i = 0; i < acc_words.size() && i < got_words.size(); i++) begin
            chk("rand_word", 32'(got_words[i]), 32'(acc_words[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
